// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
// Shares one AXI4 read slave port (AR + R channels) between NUM_MASTERS read
// masters. Round-robin arbitration, one burst at a time. The grant is taken in
// IDLE, held through the AR handshake (ADDR) and released after the RLAST beat
// (DATA). R beats are steered to the granted master only.
//
// Ports
//   aclk, areset             clock, synchronous active-high reset
//   s_ar*  / s_arvalid       packed per-master AR payload, master i at slice i
//   s_arready                per-master ARREADY (only the granted bit can be 1)
//   s_rid/s_rdata/s_rresp/s_rlast   R payload, broadcast to all masters
//   s_rvalid / s_rready      per-master R handshake
//   m_ar* / m_arvalid / m_arready   AR channel towards the slave
//   m_r*  / m_rvalid / m_rready     R channel from the slave
//   grant_cnt                per-master accepted-AR counters (16 bit, saturating),
//                            present only when AXI_RD_ARB_STATS_EN is defined
//
// Optional feature macro: AXI_RD_ARB_STATS_EN
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int AXI_ID_WIDTH   = 1,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                                 aclk,
    input  logic                                 areset,
    input  logic [NUM_MASTERS*AXI_ID_WIDTH-1:0]  s_arid,
    input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0] s_araddr,
    input  logic [NUM_MASTERS*8-1:0]             s_arlen,
    input  logic [NUM_MASTERS*3-1:0]             s_arsize,
    input  logic [NUM_MASTERS*2-1:0]             s_arburst,
    input  logic [NUM_MASTERS-1:0]               s_arvalid,
    output logic [NUM_MASTERS-1:0]               s_arready,
    output logic [AXI_ID_WIDTH-1:0]              s_rid,
    output logic [AXI_DATA_WIDTH-1:0]            s_rdata,
    output logic [1:0]                           s_rresp,
    output logic                                 s_rlast,
    output logic [NUM_MASTERS-1:0]               s_rvalid,
    input  logic [NUM_MASTERS-1:0]               s_rready,
    output logic [AXI_ID_WIDTH-1:0]              m_arid,
    output logic [AXI_ADDR_WIDTH-1:0]            m_araddr,
    output logic [7:0]                           m_arlen,
    output logic [2:0]                           m_arsize,
    output logic [1:0]                           m_arburst,
    output logic                                 m_arvalid,
    input  logic                                 m_arready,
    input  logic [AXI_ID_WIDTH-1:0]              m_rid,
    input  logic [AXI_DATA_WIDTH-1:0]            m_rdata,
    input  logic [1:0]                           m_rresp,
    input  logic                                 m_rlast,
    input  logic                                 m_rvalid,
    output logic                                 m_rready
`ifdef AXI_RD_ARB_STATS_EN
    ,
    output logic [NUM_MASTERS*16-1:0]            grant_cnt
`endif
);

    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [GW-1:0]   r_gnt;
    logic [GW-1:0]   r_last;
    logic [GW-1:0]   w_gnt_nxt;
    logic [GW-1:0]   w_last_nxt;
    logic [GW-1:0]   w_pick;
    logic            w_any;
    logic            w_addr_ph;
    logic            w_data_ph;
    logic            w_ar_hs;
    logic            w_r_done;

    // Round-robin pick: first requester at or after last+1. Scanning from the
    // farthest candidate down to the nearest lets the nearest one win.
    always_comb begin
        logic [GW-1:0] v_idx;
        v_idx  = {GW{1'b0}};
        w_pick = r_last;
        w_any  = 1'b0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            v_idx  = GW'((int'(r_last) + k) % NUM_MASTERS);
            w_pick = s_arvalid[v_idx] ? v_idx : w_pick;
            w_any  = w_any | s_arvalid[v_idx];
        end
    end

    // Handshake phases; reset forces every handshake output low immediately.
    always_comb begin
        w_addr_ph = (r_state == ST_ADDR) && !areset;
        w_data_ph = (r_state == ST_DATA) && !areset;
        w_ar_hs   = w_addr_ph && s_arvalid[r_gnt] && m_arready;
        w_r_done  = w_data_ph && m_rvalid && s_rready[r_gnt] && m_rlast;
    end

    // Next-state logic for the IDLE -> ADDR -> DATA burst sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_ADDR;
                    w_gnt_nxt   = w_pick;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ADDR: begin
                // A granted master that drops ARVALID keeps the grant; no recovery.
                if (w_ar_hs) begin
                    w_state_nxt = ST_DATA;
                end else begin
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (w_r_done) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = r_gnt;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, grant and last-served registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= ST_IDLE;
            r_gnt   <= {GW{1'b0}};
            r_last  <= GW'(NUM_MASTERS - 1);
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // AR mux and R demux, combinational so beats see no added latency.
    always_comb begin
        m_arid    = s_arid[int'(r_gnt)*AXI_ID_WIDTH +: AXI_ID_WIDTH];
        m_araddr  = s_araddr[int'(r_gnt)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        m_arlen   = s_arlen[int'(r_gnt)*8 +: 8];
        m_arsize  = s_arsize[int'(r_gnt)*3 +: 3];
        m_arburst = s_arburst[int'(r_gnt)*2 +: 2];
        m_arvalid = w_addr_ph && s_arvalid[r_gnt];
        s_arready = w_addr_ph ? (NUM_MASTERS'(m_arready) << r_gnt) : {NUM_MASTERS{1'b0}};
        m_rready  = w_data_ph && s_rready[r_gnt];
        s_rvalid  = w_data_ph ? (NUM_MASTERS'(m_rvalid) << r_gnt) : {NUM_MASTERS{1'b0}};
        s_rid     = m_rid;
        s_rdata   = m_rdata;
        s_rresp   = m_rresp;
        s_rlast   = m_rlast;
    end

`ifdef AXI_RD_ARB_STATS_EN
    logic [15:0] r_cnt [NUM_MASTERS];

    // Saturating count of accepted AR handshakes per master.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                r_cnt[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (w_ar_hs && (GW'(i) == r_gnt) && (r_cnt[i] != 16'hFFFF)) begin
                    r_cnt[i] <= r_cnt[i] + 16'd1;
                end else begin
                    r_cnt[i] <= r_cnt[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_cnt_out
        assign grant_cnt[g*16 +: 16] = r_cnt[g];
    end
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed, table-driven bench for axi_rd_arbiter with two masters. The bench
// plays both masters and the slave cycle by cycle; each table record is one
// burst with its expected grant and corner-case options.
module tb_axi_rd_arbiter;

    logic        aclk = 1'b0;
    logic        areset;
    logic [1:0]  s_arid;
    logic [63:0] s_araddr;
    logic [15:0] s_arlen;
    logic [5:0]  s_arsize;
    logic [3:0]  s_arburst;
    logic [1:0]  s_arvalid;
    logic [1:0]  s_arready;
    logic [0:0]  s_rid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic [1:0]  s_rvalid;
    logic [1:0]  s_rready;
    logic [0:0]  m_arid;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arvalid;
    logic        m_arready;
    logic [0:0]  m_rid;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic        m_rvalid;
    logic        m_rready;
`ifdef AXI_RD_ARB_STATS_EN
    logic [31:0] grant_cnt;
`endif

    axi_rd_arbiter #(
        .NUM_MASTERS(2), .AXI_ID_WIDTH(1), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready)
`ifdef AXI_RD_ARB_STATS_EN
        , .grant_cnt(grant_cnt)
`endif
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [1:0] mask;       // masters raising ARVALID in the IDLE cycle
        int         exp_m;      // master expected to win
        int         len;        // ARLEN
        int         ar_wait;    // cycles the slave holds ARREADY low
        int         stall_beat; // beat at which the master drops RREADY
        int         stall_n;    // number of stalled cycles
        int         rst_beat;   // beat during which reset is pulsed, -1 none
    } vec_t;

    vec_t vecs [12];
    int   total = 0;
    int   bad   = 0;
    int   exp_cnt [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [31:0] addr_of(input int m);
        return 32'(m) * 32'h0000_1000;
    endfunction

    function automatic logic [31:0] data_of(input int m, input int b);
        return 32'hA5A5_0000 ^ (addr_of(m) + 32'(b) * 32'd4);
    endfunction

    function automatic logic [1:0] onehot(input int m);
        return 2'(32'd1 << m);
    endfunction

    task automatic chk_quiet(input string name);
        chk(name, 64'({s_arready, s_rvalid, m_arvalid, m_rready}), 64'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int beat;
        int stalled;
        int cyc;
        logic rr;
        // IDLE cycle: requests seen, slave activity must not leak through.
        s_arlen   = {8'(v.len), 8'(v.len)};
        s_arvalid = v.mask;
        m_arready = 1'b1;
        m_rvalid  = 1'b1;
        m_rlast   = 1'b1;
        s_rready  = 2'b11;
        #1;
        chk_quiet("idle_quiet");
        step();
        // ADDR: slave may hold off ARREADY; R traffic is still not accepted.
        for (int w = 0; w < v.ar_wait; w++) begin
            m_arready = 1'b0;
            #1;
            chk("ar_wait_arvalid", 64'(m_arvalid), 64'd1);
            chk("ar_wait_arready", 64'(s_arready), 64'd0);
            chk("ar_wait_addr", 64'(m_araddr), 64'(addr_of(v.exp_m)));
            chk("ar_wait_rready", 64'({m_rready, s_rvalid}), 64'd0);
            step();
        end
        m_arready = 1'b1;
        #1;
        chk("grant_arready", 64'(s_arready), 64'(onehot(v.exp_m)));
        chk("grant_arvalid", 64'(m_arvalid), 64'd1);
        chk("grant_addr", 64'(m_araddr), 64'(addr_of(v.exp_m)));
        chk("grant_len", 64'(m_arlen), 64'(v.len));
        chk("grant_id_size_burst", 64'({m_arid, m_arsize, m_arburst}),
            64'({1'(v.exp_m), 3'd2, 2'd1}));
        chk("addr_rready", 64'(m_rready), 64'd0);
        exp_cnt[v.exp_m]++;
        step();
        // DATA: the losing master keeps requesting and must stay ignored.
        s_arvalid = v.mask & ~onehot(v.exp_m);
        m_arready = 1'b1;
        beat = 0;
        stalled = 0;
        cyc = 0;
        while (beat <= v.len && cyc < 200) begin
            m_rvalid = 1'b1;
            m_rdata  = data_of(v.exp_m, beat);
            m_rresp  = 2'(beat);
            m_rid    = 1'(v.exp_m);
            m_rlast  = (beat == v.len);
            if (v.rst_beat == beat) begin
                areset = 1'b1;
                #1;
                chk_quiet("rst_held_quiet");
                step();
                areset    = 1'b0;
                s_arvalid = 2'b00;
                #1;
                chk_quiet("rst_after_quiet");
                exp_cnt[0] = 0;
                exp_cnt[1] = 0;
                return;
            end
            rr = !(v.stall_n > 0 && beat == v.stall_beat && stalled < v.stall_n);
            s_rready = rr ? 2'b11 : ~onehot(v.exp_m);
            #1;
            chk("r_valid_route", 64'(s_rvalid), 64'(onehot(v.exp_m)));
            chk("r_ready", 64'(m_rready), 64'(rr));
            chk("r_data", 64'(s_rdata), 64'(data_of(v.exp_m, beat)));
            chk("r_resp_last_id", 64'({s_rresp, s_rlast, s_rid}),
                64'({2'(beat), beat == v.len, 1'(v.exp_m)}));
            chk("data_arready", 64'(s_arready), 64'd0);
            if (rr) begin
                beat++;
            end else begin
                stalled++;
            end
            cyc++;
            step();
        end
        chk("beats_delivered", 64'(beat), 64'(v.len + 1));
        s_arvalid = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //        mask  m  len wait sb sn rst
        vecs[0]  = '{2'b11, 0, 3,  0, 0, 0, -1};
        vecs[1]  = '{2'b10, 1, 3,  0, 0, 0, -1};
        vecs[2]  = '{2'b11, 0, 31, 0, 0, 0, -1};
        vecs[3]  = '{2'b11, 1, 0,  0, 0, 0, -1};
        vecs[4]  = '{2'b11, 0, 3,  5, 0, 0, -1};
        vecs[5]  = '{2'b10, 1, 31, 0, 10, 3, -1};
        vecs[6]  = '{2'b01, 0, 31, 0, 0, 0, 10};
        vecs[7]  = '{2'b11, 0, 2,  0, 0, 0, -1};
        vecs[8]  = '{2'b01, 0, 1,  0, 0, 0, -1};
        vecs[9]  = '{2'b10, 1, 1,  0, 0, 0, -1};
        vecs[10] = '{2'b01, 0, 0,  0, 0, 0, -1};
        vecs[11] = '{2'b10, 1, 0,  0, 0, 0, -1};

        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        s_arid    = 2'b10;
        s_araddr  = {addr_of(1), addr_of(0)};
        s_arlen   = 16'd0;
        s_arsize  = {3'd2, 3'd2};
        s_arburst = {2'd1, 2'd1};
        m_rid     = 1'b0;
        m_rdata   = 32'd0;
        m_rresp   = 2'd0;
        m_rlast   = 1'b1;

        // Reset with hostile inputs: everything must stay quiet.
        areset    = 1'b1;
        s_arvalid = 2'b11;
        s_rready  = 2'b11;
        m_arready = 1'b1;
        m_rvalid  = 1'b1;
        #1;
        chk_quiet("reset_held_quiet");
        step();
        step();
        areset    = 1'b0;
        s_arvalid = 2'b00;
        #1;
        chk_quiet("reset_release_quiet");
`ifdef AXI_RD_ARB_STATS_EN
        chk("reset_grant_cnt", 64'(grant_cnt), 64'd0);
`endif
        step();
        chk_quiet("idle_no_request");

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i]);
        end

`ifdef AXI_RD_ARB_STATS_EN
        chk("grant_cnt_model", 64'(grant_cnt), 64'({16'(exp_cnt[1]), 16'(exp_cnt[0])}));
        chk("grant_cnt_fixed", 64'(grant_cnt), 64'({16'd2, 16'd3}));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
